shift_word_serializer: RTL and testbench

Upstream feeder for the bidirectional serial-in shift register. It accepts a parallel word over a valid/ready handshake and replays it as a serial bit stream on the register's data, enable and direction inputs (ser_d, ser_en, ser_dir). After WIDTH enabled shifts the downstream register holds the word in its original bit order. Sits between the word-level producer and the shift register, in the shifter datapath.

---
 rtl/shift_word_serializer.sv | 122 ++++++++++++
 tb/tb_shift_word_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_word_serializer.sv
// Parallel-word to serial-bit feeder for the bidirectional shift register.
// Replays each accepted word on ser_d/ser_en/ser_dir, then idles GAP_CYCLES.
module shift_word_serializer #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_d,
  output logic             ser_en,
  output logic             ser_dir,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GLAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [3:0]       gcnt, gcnt_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic             msb, msb_n;
  logic             d_n, en_n, dir_n;
  logic             busy_n, done_n;

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      gcnt    <= '0;
      shadow  <= '0;
      msb     <= 1'b0;
      ser_d   <= 1'b0;
      ser_en  <= 1'b0;
      ser_dir <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      gcnt    <= gcnt_n;
      shadow  <= shadow_n;
      msb     <= msb_n;
      ser_d   <= d_n;
      ser_en  <= en_n;
      ser_dir <= dir_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so they can be registered.
  always_comb begin
    state_n  = state;
    count_n  = count;
    gcnt_n   = gcnt;
    shadow_n = shadow;
    msb_n    = msb;
    dir_n    = ser_dir;
    d_n      = 1'b0;
    en_n     = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          shadow_n = in_data;
          msb_n    = in_msb_first;
          dir_n    = !in_msb_first;
          count_n  = '0;
          en_n     = 1'b1;
          busy_n   = 1'b1;
          d_n      = in_msb_first ? in_data[WIDTH-1]
                                  : in_data[0];
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (count == LAST) begin
          done_n = 1'b1;
          if (GAP_CYCLES > 0) begin
            gcnt_n  = '0;
            busy_n  = 1'b1;
            state_n = GAP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          count_n = count + 1'b1;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          d_n     = msb ? shadow[LAST - count_n]
                        : shadow[count_n];
        end
      end
      GAP: begin
        if (gcnt == GLAST) begin
          state_n = IDLE;
        end else begin
          gcnt_n = gcnt + 1'b1;
          busy_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_word_serializer.sv
// Scoreboard bench: instance 0 has no gap, instance 1 has a 2-cycle gap.
// Monitor rebuilds the downstream register and bit stream per word.
module tb_shift_word_serializer;

  localparam int W  = 4;
  localparam int NI = 2;

  typedef struct packed {
    logic [W-1:0] data;
    logic         msb;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data  [NI];
  logic         in_msb   [NI];
  logic         in_valid [NI];
  logic         in_ready [NI];
  logic         ser_d    [NI];
  logic         ser_en   [NI];
  logic         ser_dir  [NI];
  logic         busy     [NI];
  logic         done     [NI];

  exp_t         sbq [NI][$];
  int           passed = 0;
  int           total  = 0;
  logic         gapchk [NI];
  int           idle   [NI];
  int           nb     [NI];
  logic [W-1:0] sh     [NI];
  logic [W-1:0] st     [NI];
  logic         pen    [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    shift_word_serializer #(
      .WIDTH(W),
      .GAP_CYCLES(2 * g)
    ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data[g]),
      .in_msb_first(in_msb[g]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .ser_d(ser_d[g]),
      .ser_en(ser_en[g]),
      .ser_dir(ser_dir[g]),
      .busy(busy[g]),
      .done(done[g])
    );
  end

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Bit k of the result is the k-th bit on the wire.
  function automatic logic [W-1:0] ref_stream(logic [W-1:0] d, logic m);
    logic [W-1:0] s;
    for (int k = 0; k < W; k++) s[k] = m ? d[W-1-k] : d[k];
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        sbq[i].delete();
        nb[i]   = 0;
        idle[i] = 0;
        pen[i]  = 1'b0;
      end else begin
        if (ser_en[i]) begin
          if (sbq[i].size() == 0) begin
            check("unexpected_en", 1, 0);
          end else begin
            check("ser_dir", int'(ser_dir[i]), int'(!sbq[i][0].msb));
            check("busy_in_shift", int'(busy[i]), 1);
            if (nb[i] >= W) check("overrun", nb[i], W - 1);
            st[i] = {ser_d[i], st[i][W-1:1]};
            sh[i] = ser_dir[i] ? {ser_d[i], sh[i][W-1:1]}
                               : {sh[i][W-2:0], ser_d[i]};
            nb[i]++;
          end
          if (!pen[i] && gapchk[i]) begin
            check("gap_idle", idle[i], 1 + 2 * i);
            gapchk[i] = 1'b0;
          end
          idle[i] = 0;
        end else begin
          check("ser_d_idle", int'(ser_d[i]), 0);
          idle[i]++;
        end
        if (done[i]) begin
          check("done_after_en", int'(pen[i] && !ser_en[i]), 1);
          if (sbq[i].size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sbq[i].pop_front();
            check("bit_count", nb[i], W);
            check("stream", int'(st[i]), int'(ref_stream(e.data, e.msb)));
            check("downstream", int'(sh[i]), int'(e.data));
            check("busy_at_done", int'(busy[i]), int'(i > 0));
          end
          nb[i] = 0;
        end
        pen[i] = ser_en[i];
      end
    end
  end

  task automatic send(input int i, input logic [W-1:0] d,
                      input logic m, input bit hold, output bit dn);
    int t = 0;
    in_data[i]  = d;
    in_msb[i]   = m;
    in_valid[i] = 1'b1;
    dn = 1'b0;
    while (!in_ready[i] && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      check("accept_timeout", t, 0);
    end else begin
      dn = done[i];
      sbq[i].push_back('{data: d, msb: m});
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while ((sbq[i].size() != 0 || busy[i]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("drain_timeout", t, 0);
    @(negedge clk);
  endtask

  initial begin
    bit dn;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_data[i]  = 4'hC;
      in_msb[i]   = 1'b1;
      in_valid[i] = (i == 0);
      gapchk[i]   = 1'b0;
      idle[i]     = 0;
      nb[i]       = 0;
      sh[i]       = '0;
      st[i]       = '0;
      pen[i]      = 1'b0;
    end

    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check("rst_ready", int'(in_ready[i]), 0);
        check("rst_outs", int'({ser_d[i], ser_en[i], ser_dir[i],
                                busy[i], done[i]}), 0);
      end
    end
    rst = 1'b0;
    #1;
    check("ready_after_rst", int'(in_ready[0]), 1);
    sbq[0].push_back('{data: 4'hC, msb: 1'b1});
    @(posedge clk);
    #1;
    check("first_edge_accept", int'(busy[0] && ser_en[0]), 1);
    in_valid[0] = 1'b0;
    wait_idle(0);

    send(0, 4'b1011, 1'b1, 1'b0, dn);
    wait_idle(0);
    send(0, 4'b0110, 1'b0, 1'b0, dn);
    wait_idle(0);

    for (int i = 0; i < NI; i++) begin
      send(i, 4'hA, 1'b1, 1'b1, dn);
      @(negedge clk);
      #1;
      gapchk[i] = 1'b1;
      send(i, 4'h5, 1'b1, 1'b0, dn);
      check("accept_on_done", int'(dn), int'(i == 0));
      wait_idle(i);
      check("gap_seen", int'(gapchk[i]), 0);
    end

    send(0, 4'b1100, 1'b1, 1'b0, dn);
    @(negedge clk);
    in_data[0]  = 4'hF;
    in_valid[0] = 1'b1;
    #1;
    check("ready_in_shift", int'(in_ready[0]), 0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_idle(0);
    repeat (6) @(negedge clk);

    send(0, 4'b0111, 1'b1, 1'b0, dn);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_en", int'(ser_en[0]), 0);
    check("rst_mid_busy", int'(busy[0]), 0);
    check("rst_mid_done", int'(done[0]), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(0, 4'b1001, 1'b1, 1'b0, dn);
    wait_idle(0);

    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 12; k++) begin
        bit hold;
        hold = (k < 11) && ($urandom_range(0, 2) != 0);
        send(i, W'($urandom), 1'($urandom), hold, dn);
        if (!hold) repeat ($urandom_range(0, 7)) @(negedge clk);
      end
      wait_idle(i);
    end

    for (int i = 0; i < NI; i++) check("drained", sbq[i].size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
